// File: rtl/maze_grid_renderer_pkg.sv
// maze_grid_renderer_pkg: RGB332 colours, region and clear-FSM encodings shared by the grid renderer.
package maze_grid_renderer_pkg;
    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;
    localparam logic [7:0] RED = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE = 8'h03;
    typedef enum logic [1:0] {R_OUTSIDE, R_LINE, R_CELL} region_t;
    typedef enum logic {S_IDLE, S_CLEAR} fsm_t;
    function automatic logic [7:0] palette(input int unsigned s);
        return s == 0 ? BLACK : s == 1 ? GREEN : s == 2 ? BLUE : s == 3 ? RED : WHITE;
    endfunction
endpackage

// File: rtl/maze_grid_renderer_if.sv
// maze_grid_renderer_if: pixel stream in, cell write port, clear pulse and colour out of the renderer.
interface maze_grid_renderer_if #(parameter int ROWS = 16, COLS = 21, STATE_W = 2);
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic wr_en;
    logic [$clog2(ROWS)-1:0] wr_row;
    logic [$clog2(COLS)-1:0] wr_col;
    logic [STATE_W-1:0] wr_data;
    logic clear;
    logic wr_ready;
    logic wr_err;
    logic [7:0] color_out;
    modport master (
        output pixel_x, pixel_y, wr_en, wr_row, wr_col, wr_data, clear,
        input wr_ready, wr_err, color_out
    );
    modport slave (
        input pixel_x, pixel_y, wr_en, wr_row, wr_col, wr_data, clear,
        output wr_ready, wr_err, color_out
    );
endinterface

// File: rtl/maze_grid_renderer_grid_pos_tracker.sv
// maze_grid_renderer_grid_pos_tracker: follows the VGA pixel stream with wrap counters and registers
// the cell row/col and region of the current pixel.
module maze_grid_renderer_grid_pos_tracker import maze_grid_renderer_pkg::*; #(
    parameter int CELL_PX = 30, COLS = 21, ROWS = 16, SCREEN_W = 640, SCREEN_H = 480
) (
    input logic clk,
    input logic rst_n,
    input logic [9:0] pixel_x,
    input logic [9:0] pixel_y,
    output logic [$clog2(ROWS)-1:0] row,
    output logic [$clog2(COLS)-1:0] col,
    output region_t region
);
    localparam int OW = $clog2(CELL_PX);
    localparam logic [9:0] W = 10'(COLS * CELL_PX);
    localparam logic [9:0] H = 10'(ROWS * CELL_PX);
    localparam logic [9:0] SW = 10'(SCREEN_W);
    localparam logic [9:0] SH = 10'(SCREEN_H);
    logic [OW-1:0] x_off, y_off, nx_off, ny_off;
    logic [$clog2(ROWS)-1:0] nrow;
    logic [$clog2(COLS)-1:0] ncol;
    logic x_wrap, y_wrap;
    region_t nregion;

    // row tracking only moves at the start of each line
    always_comb begin
        x_wrap = x_off == OW'(CELL_PX - 1);
        y_wrap = y_off == OW'(CELL_PX - 1);
        nx_off = pixel_x == '0 || x_wrap ? '0 : x_off + 1'b1;
        ncol = pixel_x == '0 ? '0 : x_wrap ? col + 1'b1 : col;
        ny_off = pixel_x != '0 ? y_off : pixel_y == '0 || y_wrap ? '0 : y_off + 1'b1;
        nrow = pixel_x != '0 ? row : pixel_y == '0 ? '0 : y_wrap ? row + 1'b1 : row;
        nregion = pixel_x > W || pixel_y > H || pixel_x >= SW || pixel_y >= SH ? R_OUTSIDE
                : nx_off == '0 || ny_off == '0 || pixel_x == W || pixel_y == H ? R_LINE : R_CELL;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x_off <= '0;
            y_off <= '0;
            row <= '0;
            col <= '0;
            region <= R_OUTSIDE;
        end else begin
            x_off <= nx_off;
            y_off <= ny_off;
            row <= nrow;
            col <= ncol;
            region <= nregion;
        end
endmodule

// File: rtl/maze_grid_renderer.sv
// maze_grid_renderer: ROWS x COLS cell-state grid rendered as RGB332 two clocks after each pixel,
// with a single-cycle write port and a one-cell-per-clock clear sweep.
module maze_grid_renderer import maze_grid_renderer_pkg::*; #(
    parameter int CELL_PX = 30, COLS = 21, ROWS = 16, STATE_W = 2, SCREEN_W = 640, SCREEN_H = 480
) (
    input logic clk,
    input logic rst_n,
    maze_grid_renderer_if.slave bus
);
    localparam int N = ROWS * COLS;
    localparam int IW = $clog2(N);
    logic [STATE_W-1:0] cells [N];
    logic [$clog2(ROWS)-1:0] row;
    logic [$clog2(COLS)-1:0] col;
    region_t region;
    fsm_t state, state_nx;
    logic [IW-1:0] idx, rd_idx, wr_idx;
    logic wr_ok, wr_bad;

    maze_grid_renderer_grid_pos_tracker #(
        .CELL_PX(CELL_PX), .COLS(COLS), .ROWS(ROWS), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) grid_pos_tracker (
        .clk(clk), .rst_n(rst_n), .pixel_x(bus.pixel_x), .pixel_y(bus.pixel_y),
        .row(row), .col(col), .region(region)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;

    always_comb state_nx = state == S_IDLE ? (bus.clear ? S_CLEAR : S_IDLE)
                         : (idx == IW'(N - 1) ? S_IDLE : S_CLEAR);

    always_comb bus.wr_ready = state == S_IDLE;

    // a clear arriving with a write takes priority and drops the write
    always_comb begin
        wr_ok = bus.wr_en && bus.wr_ready && !bus.clear;
        wr_bad = int'(bus.wr_row) >= ROWS || int'(bus.wr_col) >= COLS;
        wr_idx = IW'(bus.wr_row) * IW'(COLS) + IW'(bus.wr_col);
        rd_idx = region == R_CELL ? IW'(row) * IW'(COLS) + IW'(col) : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cells[i] <= '0;
            idx <= '0;
            bus.wr_err <= 1'b0;
            bus.color_out <= BLACK;
        end else begin
            if (state == S_CLEAR) cells[idx] <= '0;
            else if (wr_ok && !wr_bad) cells[wr_idx] <= bus.wr_data;
            idx <= state == S_CLEAR ? idx + 1'b1 : '0;
            bus.wr_err <= wr_ok && wr_bad;
            bus.color_out <= region == R_OUTSIDE ? BLACK : region == R_LINE ? WHITE
                           : palette(32'(cells[rd_idx]));
        end
endmodule

// File: tb/tb_maze_grid_renderer.sv
// tb_maze_grid_renderer: drives a 30-px 21x16 grid and a 20-px 8x8 grid with one pixel/write stream;
// expected colours are queued at issue time and popped by a monitor two clocks later.
module tb_maze_grid_renderer;
    typedef struct {int x; int y; logic [7:0] c;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit pix_vld = 1'b0, v1 = 1'b0, v2 = 1'b0;
    int total = 0, bad = 0, cur_y = -1, na, nb;
    int ma [16][32];
    int mb [8][32];
    exp_t qa[$], qb[$];
    exp_t ea, eb;

    maze_grid_renderer_if #(.ROWS(16), .COLS(21), .STATE_W(2)) ba ();
    maze_grid_renderer_if #(.ROWS(8), .COLS(8), .STATE_W(2)) bb ();
    maze_grid_renderer dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    maze_grid_renderer #(.CELL_PX(20), .COLS(8), .ROWS(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

    always #20 clk = ~clk;

    function automatic logic [7:0] pal(int s);
        return s == 0 ? 8'h00 : s == 1 ? 8'h1C : s == 2 ? 8'h03 : s == 3 ? 8'hE0 : 8'hFF;
    endfunction

    // -1 outside, -2 grid line, otherwise row*32+col
    function automatic int classify(int x, int y, int cp, int cols, int rows);
        if (x > cols * cp || y > rows * cp || x >= 640 || y >= 480) return -1;
        if (x % cp == 0 || y % cp == 0 || x == cols * cp || y == rows * cp) return -2;
        return (y / cp) * 32 + x / cp;
    endfunction

    function automatic logic [7:0] exp_a(int x, int y);
        int k = classify(x, y, 30, 21, 16);
        return k == -1 ? 8'h00 : k == -2 ? 8'hFF : pal(ma[k / 32][k % 32]);
    endfunction

    function automatic logic [7:0] exp_b(int x, int y);
        int k = classify(x, y, 20, 8, 8);
        return k == -1 ? 8'h00 : k == -2 ? 8'hFF : pal(mb[k / 32][k % 32]);
    endfunction

    task automatic zero_a();
        for (int r = 0; r < 16; r++) for (int c = 0; c < 32; c++) ma[r][c] = 0;
    endtask

    task automatic zero_b();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 32; c++) mb[r][c] = 0;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(int x, int y, bit pv, bit we = 0, int r = 0, int c = 0, int d = 0, bit clr = 0);
        exp_t e;
        @(negedge clk);
        ba.pixel_x = 10'(x); ba.pixel_y = 10'(y);
        bb.pixel_x = 10'(x); bb.pixel_y = 10'(y);
        ba.wr_en = we; ba.wr_row = 4'(r); ba.wr_col = 5'(c); ba.wr_data = 2'(d); ba.clear = clr;
        bb.wr_en = we && r < 8 && c < 8; bb.wr_row = 3'(r); bb.wr_col = 3'(c); bb.wr_data = 2'(d);
        bb.clear = clr;
        if (clr) begin
            if (ba.wr_ready) zero_a();
            if (bb.wr_ready) zero_b();
        end else if (we) begin
            if (ba.wr_ready && r < 16 && c < 21) ma[r][c] = d;
            if (bb.wr_en && bb.wr_ready) mb[r][c] = d;
        end
        pix_vld = pv;
        if (!pv) cur_y = -1;
        else begin
            e.x = x; e.y = y;
            e.c = exp_a(x, y); qa.push_back(e);
            e.c = exp_b(x, y); qb.push_back(e);
        end
    endtask

    task automatic line(int y, int xmax);
        if (y <= cur_y) cur_y = -1;
        for (int yy = cur_y + 1; yy < y; yy++) step(0, yy, 1);
        for (int x = 0; x <= xmax; x++) step(x, y, 1);
        cur_y = y;
    endtask

    task automatic scan(bit part);
        for (int y = 0; y <= 480; y++)
            if (part ? (y inside {15, 30, 45, 75, 105, 150, 225, 465})
                     : (y % 30 == 15 || y inside {0, 30, 90, 150, 160, 479, 480})) line(y, 642);
    endtask

    always @(posedge clk) begin
        v1 <= pix_vld;
        v2 <= v1;
    end

    always @(negedge clk)
        if (v2) begin
            total += 2;
            if (qa.size() == 0 || qb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: colour presented with no expected entry");
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                if (ba.color_out !== ea.c) begin
                    bad++;
                    $display("FAIL color_a (%0d,%0d): got %02h want %02h", ea.x, ea.y, ba.color_out, ea.c);
                end
                if (bb.color_out !== eb.c) begin
                    bad++;
                    $display("FAIL color_b (%0d,%0d): got %02h want %02h", eb.x, eb.y, bb.color_out, eb.c);
                end
            end
        end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        ba.pixel_x = '0; ba.pixel_y = '0; ba.wr_en = 0; ba.wr_row = '0; ba.wr_col = '0;
        ba.wr_data = '0; ba.clear = 0;
        bb.pixel_x = '0; bb.pixel_y = '0; bb.wr_en = 0; bb.wr_row = '0; bb.wr_col = '0;
        bb.wr_data = '0; bb.clear = 0;
        #50;
        chk("rst_ready_a", ba.wr_ready, 1); chk("rst_color_a", ba.color_out, 8'h00);
        chk("rst_err_a", ba.wr_err, 0); chk("rst_ready_b", bb.wr_ready, 1);
        chk("rst_color_b", bb.color_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("post_rst_ready_a", ba.wr_ready, 1); chk("post_rst_err_a", ba.wr_err, 0);
        // empty grid: only lines and blanking
        scan(0);
        // cell (3,5)=1 on both grids
        step(0, 0, 0, 1, 3, 5, 1);
        line(70, 200);
        line(100, 200);
        // write (0,0)=2 while pixel (1,5) is reading it
        line(5, 1);
        for (int x = 2; x <= 40; x++) step(x, 5, 1, x == 2, 0, 0, 2);
        // out-of-range writes
        step(0, 0, 0, 1, 15, 21, 3); step(0, 0, 0);
        chk("err_col21", ba.wr_err, 1);
        step(0, 0, 0);
        chk("err_falls", ba.wr_err, 0);
        step(0, 0, 0, 1, 2, 25, 1); step(0, 0, 0);
        chk("err_col25", ba.wr_err, 1);
        step(0, 0, 0, 1, 15, 20, 3); step(0, 0, 0);
        chk("err_inrange", ba.wr_err, 0);
        step(0, 0, 0, 1, 7, 7, 3);
        step(0, 0, 0, 1, 8, 10, 2);
        scan(0);
        // clear together with a write; repeat clear and a write during the sweep are ignored
        step(0, 0, 0, 1, 1, 1, 3, 1);
        na = 0; nb = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 20) step(0, 0, 0, 0, 0, 0, 0, 1);
            else if (i == 30) step(0, 0, 0, 1, 2, 2, 3);
            else step(0, 0, 0);
            na += ba.wr_ready ? 0 : 1;
            nb += bb.wr_ready ? 0 : 1;
        end
        chk("clear_busy_a", na, 336);
        chk("clear_busy_b", nb, 64);
        chk("clear_done_err", ba.wr_err, 0);
        scan(1);
        // reset in the middle of a clear
        step(0, 0, 0, 1, 15, 20, 3);
        step(0, 0, 0, 1, 10, 3, 2);
        step(0, 0, 0, 1, 7, 7, 3);
        step(0, 0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 101; i++) step(0, 0, 0);
        chk("busy_before_rst", ba.wr_ready, 0);
        chk("color_before_rst", ba.color_out, 8'hFF);
        #5 rst_n = 1'b0;
        #1;
        chk("midclr_ready_a", ba.wr_ready, 1); chk("midclr_color_a", ba.color_out, 8'h00);
        chk("midclr_ready_b", bb.wr_ready, 1); chk("midclr_color_b", bb.color_out, 8'h00);
        zero_a(); zero_b();
        @(negedge clk);
        rst_n = 1'b1;
        cur_y = -1;
        scan(1);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
